// File: rtl/vend_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Purpose  : Shared definitions for the vending controller: coin encodings,
//            controller state enum and the coin-to-credit-units helper.
// Revision : 1.0  initial release
// ============================================================================
package vend_pkg;

    // Coin input encodings (credit is counted in 5c units)
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5C   = 2'b01;
    localparam logic [1:0] COIN_10C  = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_e;

    // Credit value of a coin in 5c units; anything not a real coin is worth 0
    function automatic logic [1:0] coin_units(input logic [1:0] coin_code);
        logic [1:0] units;
        case (coin_code)
            COIN_5C:  units = 2'd1;
            COIN_10C: units = 2'd2;
            default:  units = 2'd0;
        endcase
        return units;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vend_change_unit
// Purpose  : Change pay-out down-counter. While active, each cycle with
//            nonzero credit returns one 5c coin (registered change_pulse) and
//            hands back the decremented credit; done flags an empty credit.
// Ports    : clk, reset       - clock, asynchronous active-high reset
//            active           - controller is in the CHANGE state
//            credit_in        - current credit register value
//            credit_next      - credit value for the next cycle
//            done             - active with credit already at zero
//            change_pulse     - one returned coin per asserted cycle
// Revision : 1.0  initial release
// ============================================================================
module vend_change_unit #(
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                active,
    input  logic [CREDIT_W-1:0] credit_in,
    output logic [CREDIT_W-1:0] credit_next,
    output logic                done,
    output logic                change_pulse
);

    logic change_pulse_d;
    logic change_pulse_q;

    always_comb begin
        change_pulse_d = active && (credit_in != '0);
        done           = active && (credit_in == '0);
        credit_next    = change_pulse_d ? (credit_in - CREDIT_W'(1)) : credit_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            change_pulse_q <= 1'b0;
        end else begin
            change_pulse_q <= change_pulse_d;
        end
    end

    assign change_pulse = change_pulse_q;

endmodule
`default_nettype wire

// File: rtl/vend_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vend_controller
// Purpose  : Coin-operated vending controller: accumulates credit, checks
//            selections against per-slot price/stock, dispenses, and pays
//            change back one 5c coin per cycle.
// Ports    : clk, reset (async, active-high)
//            coin, sel_valid/sel_id, cancel       - customer inputs
//            cfg_we/cfg_id/cfg_price/cfg_stock    - slot configuration (IDLE only)
//            vend_valid/vend_id, change_pulse     - dispense / change outputs
//            coin_reject, sel_reject              - one-cycle rejection flags
//            credit, busy, sold_out               - status
// Options  : VEND_TIMEOUT_EN - auto-refund after TIMEOUT_CYC idle CREDIT cycles
// Revision : 1.0  initial release
// ============================================================================
module vend_controller
    import vend_pkg::*;
#(
    parameter  int NUM_ITEMS   = 4,
    parameter  int CREDIT_W    = 6,
    parameter  int STOCK_W     = 4,
    parameter  int TIMEOUT_CYC = 1000,
    localparam int ID_W        = $clog2(NUM_ITEMS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           coin,
    input  logic                 sel_valid,
    input  logic [ID_W-1:0]      sel_id,
    input  logic                 cancel,
    input  logic                 cfg_we,
    input  logic [ID_W-1:0]      cfg_id,
    input  logic [CREDIT_W-1:0]  cfg_price,
    input  logic [STOCK_W-1:0]   cfg_stock,
    output logic                 vend_valid,
    output logic [ID_W-1:0]      vend_id,
    output logic                 change_pulse,
    output logic                 coin_reject,
    output logic                 sel_reject,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 busy,
    output logic [NUM_ITEMS-1:0] sold_out
);

    localparam logic [ID_W:0] NUM_ITEMS_L = NUM_ITEMS[ID_W:0];

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] price_q [NUM_ITEMS];
    logic [CREDIT_W-1:0] price_d [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
    logic                vend_valid_q, vend_valid_d;
    logic [ID_W-1:0]     vend_id_q, vend_id_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_reject_q, sel_reject_d;

    logic [CREDIT_W:0]   w_coin_sum;
    logic                w_coin_ok;
    logic                w_sel_in_range;
    logic                w_cfg_in_range;
    logic [CREDIT_W-1:0] w_change_credit;
    logic                w_change_done;

    // One spare bit catches a coin that would overflow the credit register
    assign w_coin_sum     = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, coin_units(coin)};
    assign w_coin_ok      = (coin_units(coin) != 2'd0) && !w_coin_sum[CREDIT_W];
    assign w_sel_in_range = ({1'b0, sel_id} < NUM_ITEMS_L);
    assign w_cfg_in_range = ({1'b0, cfg_id} < NUM_ITEMS_L);

`ifdef VEND_TIMEOUT_EN
    localparam int          TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             w_credit_event;

    // Any customer activity in CREDIT restarts the inactivity window
    assign w_credit_event = cancel | sel_valid | w_coin_ok;
`endif

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        price_d       = price_q;
        stock_d       = stock_q;
        vend_valid_d  = 1'b0;
        vend_id_d     = vend_id_q;
        coin_reject_d = 1'b0;
        sel_reject_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_we && w_cfg_in_range) begin
                    price_d[cfg_id] = cfg_price;
                    stock_d[cfg_id] = cfg_stock;
                end
                sel_reject_d = sel_valid;
                // A selection in the same cycle always bounces the coin
                if (coin != COIN_NONE) begin
                    if (w_coin_ok && !sel_valid) begin
                        credit_d = w_coin_sum[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            ST_CREDIT: begin
                if (cancel) begin
                    // Full refund; a simultaneous selection is dropped silently
                    state_d       = ST_CHANGE;
                    coin_reject_d = (coin != COIN_NONE);
                end else if (sel_valid) begin
                    // Judged against credit before any same-cycle coin
                    coin_reject_d = (coin != COIN_NONE);
                    if (!w_sel_in_range || (stock_q[sel_id] == '0) ||
                        (credit_q < price_q[sel_id])) begin
                        sel_reject_d = 1'b1;
                    end else begin
                        vend_valid_d    = 1'b1;
                        vend_id_d       = sel_id;
                        stock_d[sel_id] = stock_q[sel_id] - STOCK_W'(1);
                        credit_d        = credit_q - price_q[sel_id];
                        state_d         = ST_VEND;
                    end
                end else if (coin != COIN_NONE) begin
                    if (w_coin_ok) begin
                        credit_d = w_coin_sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            ST_VEND: begin
                coin_reject_d = (coin != COIN_NONE);
                sel_reject_d  = sel_valid;
                state_d       = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end

            ST_CHANGE: begin
                coin_reject_d = (coin != COIN_NONE);
                sel_reject_d  = sel_valid;
                credit_d      = w_change_credit;
                if (w_change_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef VEND_TIMEOUT_EN
        timer_d = '0;
        if ((state_q == ST_CREDIT) && !w_credit_event) begin
            if (timer_q == TMO_LAST) begin
                state_d = ST_CHANGE;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            vend_valid_q  <= 1'b0;
            vend_id_q     <= '0;
            coin_reject_q <= 1'b0;
            sel_reject_q  <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                price_q[i] <= '0;
                stock_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_valid_q  <= vend_valid_d;
            vend_id_q     <= vend_id_d;
            coin_reject_q <= coin_reject_d;
            sel_reject_q  <= sel_reject_d;
            price_q       <= price_d;
            stock_q       <= stock_d;
        end
    end

`ifdef VEND_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    vend_change_unit #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .clk          (clk),
        .reset        (reset),
        .active       (state_q == ST_CHANGE),
        .credit_in    (credit_q),
        .credit_next  (w_change_credit),
        .done         (w_change_done),
        .change_pulse (change_pulse)
    );

    generate
        for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_sold_out
            assign sold_out[gi] = (stock_q[gi] == '0);
        end
    endgenerate

    assign vend_valid  = vend_valid_q;
    assign vend_id     = vend_id_q;
    assign coin_reject = coin_reject_q;
    assign sel_reject  = sel_reject_q;
    assign credit      = credit_q;
    assign busy        = (state_q == ST_VEND) || (state_q == ST_CHANGE);

endmodule
`default_nettype wire
